// File: rtl/conv_unit.sv
// conv_unit: WebAssembly numeric-conversion unit.
//
// Executes reinterpret (0xBC-0xBF), wrap (0xA7), extend (0xAC/0xAD) and
// float->int truncation (0xA8-0xAB, 0xAE-0xB1). Simple ops complete one
// cycle after accept. Truncation decodes the float, then aligns the
// significand to the binary point with an iterative shifter. Wasm traps
// (overflow, NaN, unsupported op) are reported instead of a result.
//
// Parameters:
//   USE_64B    - 1 enables i64/f64 ops; 0 makes every 64-bit op TRAP_UNSUP
//   HAS_FPU    - 1 enables truncation; 0 makes trunc ops TRAP_UNSUP
//   SHIFT_STEP - significand bits shifted per SHIFT cycle (1..16)
//
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset
//   in_valid  - operation offered
//   in_ready  - unit idle with empty output register (registered)
//   in_op     - Wasm opcode byte
//   in_data   - operand; 32-bit types use [31:0]
//   out_valid - result or trap held until out_ready
//   out_ready - consumer takes the result
//   out_data  - result; 32-bit results zero-extended, 0 on trap
//   out_type  - 0 i32, 1 i64, 2 f32, 3 f64
//   out_trap  - 0 none, 1 overflow, 2 NaN, 3 unsupported
module conv_unit #(
   parameter bit USE_64B    = 1'b1,
   parameter bit HAS_FPU    = 1'b1,
   parameter int SHIFT_STEP = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_op,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic [1:0]  out_type,
   output logic [1:0]  out_trap
);

   localparam logic [1:0] TYPE_I32 = 2'd0;
   localparam logic [1:0] TYPE_I64 = 2'd1;
   localparam logic [1:0] TYPE_F32 = 2'd2;
   localparam logic [1:0] TYPE_F64 = 2'd3;

   localparam logic [1:0] TRAP_NONE  = 2'd0;
   localparam logic [1:0] TRAP_OVF   = 2'd1;
   localparam logic [1:0] TRAP_NAN   = 2'd2;
   localparam logic [1:0] TRAP_UNSUP = 2'd3;

   localparam logic [6:0] STEP = 7'(SHIFT_STEP);

   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_SHIFT, S_DONE} state_t;

   state_t      state;
   logic [63:0] data_q;
   logic        src64_q;
   logic        dst64_q;
   logic        signed_q;
   logic [63:0] mant_q;
   logic [6:0]  rem_q;
   logic        left_q;

   // Applies the sign for negative signed results and narrows to 32 bits
   // with zero extension when the destination is i32.
   function automatic logic [63:0] finish(input logic [63:0] m, input logic negate, input logic wide);
      logic [63:0] r;
      r = negate ? (~m + 64'd1) : m;
      return wide ? r : {32'h0, r[31:0]};
   endfunction

   // Classification of the offered opcode: simple ops get their result
   // computed here so they can be registered at the accept edge.
   logic        acc_trunc;
   logic        acc_wide;
   logic        acc_src64;
   logic [1:0]  acc_type;
   logic [1:0]  acc_trap;
   logic [63:0] acc_data;

   always_comb begin
      acc_trunc = 1'b0;
      acc_wide  = 1'b0;
      acc_src64 = 1'b0;
      acc_type  = TYPE_I32;
      acc_trap  = TRAP_NONE;
      acc_data  = '0;
      case (in_op)
         8'hA7: begin acc_wide = 1'b1; acc_data = {32'h0, in_data[31:0]}; end
         8'hAC: begin acc_wide = 1'b1; acc_type = TYPE_I64; acc_data = {{32{in_data[31]}}, in_data[31:0]}; end
         8'hAD: begin acc_wide = 1'b1; acc_type = TYPE_I64; acc_data = {32'h0, in_data[31:0]}; end
         8'hBC: begin acc_data = {32'h0, in_data[31:0]}; end
         8'hBD: begin acc_wide = 1'b1; acc_type = TYPE_I64; acc_data = in_data; end
         8'hBE: begin acc_type = TYPE_F32; acc_data = {32'h0, in_data[31:0]}; end
         8'hBF: begin acc_wide = 1'b1; acc_type = TYPE_F64; acc_data = in_data; end
         8'hA8, 8'hA9: begin acc_trunc = 1'b1; end
         8'hAA, 8'hAB: begin acc_trunc = 1'b1; acc_wide = 1'b1; acc_src64 = 1'b1; end
         8'hAE, 8'hAF: begin acc_trunc = 1'b1; acc_wide = 1'b1; acc_type = TYPE_I64; end
         8'hB0, 8'hB1: begin acc_trunc = 1'b1; acc_wide = 1'b1; acc_src64 = 1'b1; acc_type = TYPE_I64; end
         default: acc_trap = TRAP_UNSUP;
      endcase
      if ((acc_wide && !USE_64B) || (acc_trunc && !HAS_FPU)) begin
         acc_trap  = TRAP_UNSUP;
         acc_trunc = 1'b0;
      end
      if (acc_trap != TRAP_NONE) acc_data = '0;
   end

   // Float decode of the latched operand: exponent, significand with the
   // hidden bit, and the trap / zero / shift decision for the DECODE cycle.
   logic               frac_zero;
   logic               exp_max;
   logic               neg;
   logic signed [12:0] e_unb;
   logic signed [12:0] diff;
   logic signed [12:0] wm1;
   logic [63:0]        dec_mant;
   logic [6:0]         dec_rem;
   logic               dec_left;
   logic               dec_zero;
   logic [1:0]         dec_trap;

   always_comb begin
      if (src64_q) begin
         frac_zero = (data_q[51:0] == 52'h0);
         exp_max   = &data_q[62:52];
         neg       = data_q[63];
         e_unb     = $signed({2'b00, data_q[62:52]}) - 13'sd1023;
         dec_mant  = {11'h0, 1'b1, data_q[51:0]};
         diff      = e_unb - 13'sd52;
      end else begin
         frac_zero = (data_q[22:0] == 23'h0);
         exp_max   = &data_q[30:23];
         neg       = data_q[31];
         e_unb     = $signed({5'b00000, data_q[30:23]}) - 13'sd127;
         dec_mant  = {40'h0, 1'b1, data_q[22:0]};
         diff      = e_unb - 13'sd23;
      end
      wm1      = dst64_q ? 13'sd63 : 13'sd31;
      dec_left = ~diff[12];
      dec_rem  = diff[12] ? 7'(-diff) : 7'(diff);
      dec_zero = 1'b0;
      dec_trap = TRAP_NONE;
      if (exp_max && !frac_zero)
         dec_trap = TRAP_NAN;
      else if (exp_max)
         dec_trap = TRAP_OVF;
      else if (e_unb < 13'sd0)
         dec_zero = 1'b1;
      else if (signed_q) begin
         // Only -2^(W-1) itself reaches the top exponent legally.
         if (e_unb > wm1)
            dec_trap = TRAP_OVF;
         else if ((e_unb == wm1) && !(neg && frac_zero))
            dec_trap = TRAP_OVF;
      end else begin
         if (neg || (e_unb > wm1))
            dec_trap = TRAP_OVF;
      end
   end

   // One shifter step: never moves past the binary point.
   logic [6:0]  step_amt;
   logic [6:0]  rem_next;
   logic [63:0] mant_next;

   always_comb begin
      step_amt  = (rem_q < STEP) ? rem_q : STEP;
      rem_next  = rem_q - step_amt;
      mant_next = left_q ? (mant_q << step_amt) : (mant_q >> step_amt);
   end

   // Control FSM with registered handshake and result outputs. Results are
   // written on entry to DONE and out_valid rises one cycle later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_type  <= TYPE_I32;
         out_trap  <= TRAP_NONE;
         data_q    <= '0;
         src64_q   <= 1'b0;
         dst64_q   <= 1'b0;
         signed_q  <= 1'b0;
         mant_q    <= '0;
         rem_q     <= '0;
         left_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  out_type <= acc_type;
                  if (acc_trunc) begin
                     data_q   <= in_data;
                     src64_q  <= acc_src64;
                     dst64_q  <= (acc_type == TYPE_I64);
                     signed_q <= ~in_op[0];
                     state    <= S_DECODE;
                  end else begin
                     out_data <= acc_data;
                     out_trap <= acc_trap;
                     state    <= S_DONE;
                  end
               end
            end
            S_DECODE: begin
               if (dec_trap != TRAP_NONE) begin
                  out_data <= '0;
                  out_trap <= dec_trap;
                  state    <= S_DONE;
               end else if (dec_zero) begin
                  out_data <= '0;
                  out_trap <= TRAP_NONE;
                  state    <= S_DONE;
               end else if (dec_rem == 7'd0) begin
                  out_data <= finish(dec_mant, signed_q & neg, dst64_q);
                  out_trap <= TRAP_NONE;
                  state    <= S_DONE;
               end else begin
                  mant_q <= dec_mant;
                  rem_q  <= dec_rem;
                  left_q <= dec_left;
                  state  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (rem_next == 7'd0) begin
                  out_data <= finish(mant_next, signed_q & neg, dst64_q);
                  out_trap <= TRAP_NONE;
                  state    <= S_DONE;
               end else begin
                  mant_q <= mant_next;
                  rem_q  <= rem_next;
               end
            end
            S_DONE: begin
               if (!out_valid)
                  out_valid <= 1'b1;
               else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
